// File: rtl/regwr_arbiter_if.sv
// regwr_arbiter_if
// Bundles the signals between the register-file write-port arbiter and its
// neighbours: the writeback stage, the MDU, the decode hazard check and the
// register file write port.
//   slave  modport : arbiter side (requests in, stall/ready/busy/write port out)
//   master modport : pipeline/MDU/regfile side (the mirror image)
// Signals:
//   wb_wren/wb_addr/wb_data          writeback request
//   wb_stall                         writeback must hold off this cycle
//   mdu_issue/mdu_issue_addr         MDU op issued, reserve destination
//   mdu_valid/mdu_ready              MDU result handshake
//   mdu_addr/mdu_data                MDU result destination/data
//   busy_addr_a/b, busy_a/b          decode source hazard query
//   rf_wren/rf_addr_w/rf_data_w      register file write port
interface regwr_arbiter_if;
  logic        wb_wren;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        wb_stall;
  logic        mdu_issue;
  logic [4:0]  mdu_issue_addr;
  logic        mdu_valid;
  logic        mdu_ready;
  logic [4:0]  mdu_addr;
  logic [31:0] mdu_data;
  logic [4:0]  busy_addr_a;
  logic [4:0]  busy_addr_b;
  logic        busy_a;
  logic        busy_b;
  logic        rf_wren;
  logic [4:0]  rf_addr_w;
  logic [31:0] rf_data_w;

  modport slave (
    input  wb_wren, wb_addr, wb_data,
    output wb_stall,
    input  mdu_issue, mdu_issue_addr,
    input  mdu_valid,
    output mdu_ready,
    input  mdu_addr, mdu_data,
    input  busy_addr_a, busy_addr_b,
    output busy_a, busy_b,
    output rf_wren, rf_addr_w, rf_data_w
  );

  modport master (
    output wb_wren, wb_addr, wb_data,
    input  wb_stall,
    output mdu_issue, mdu_issue_addr,
    output mdu_valid,
    input  mdu_ready,
    output mdu_addr, mdu_data,
    output busy_addr_a, busy_addr_b,
    input  busy_a, busy_b,
    input  rf_wren, rf_addr_w, rf_data_w
  );
endinterface

// File: rtl/regwr_arbiter.sv
// regwr_arbiter
// Shares the single register-file write port between the pipeline writeback
// stage (fixed priority) and a one-entry MDU result buffer, and keeps a
// 32-bit scoreboard of destinations reserved by in-flight MDU operations.
// Ports:
//   clk   : clock, all state updates on the rising edge
//   aclr  : synchronous active-high reset
//   bus   : regwr_arbiter_if.slave (writeback, MDU, hazard query, write port)
// Parameter:
//   STARVE_MAX : cycles a buffered MDU result may lose to WB before wb_stall
// Build option:
//   REGWR_ARB_STARVE_EN : when defined, the starvation counter and wb_stall
//                         are built; otherwise wb_stall is tied low and a
//                         buffered result waits for an idle WB cycle.
module regwr_arbiter #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic            clk,
  input  logic            aclr,
  regwr_arbiter_if.slave  bus
);

  if ((STARVE_MAX < 1) || (STARVE_MAX > 15)) begin : g_bad_starve_max
    $error("regwr_arbiter: STARVE_MAX must be within 1..15");
  end

  logic        buf_full_q, buf_full_d;
  logic [4:0]  buf_addr_q, buf_addr_d;
  logic [31:0] buf_data_q, buf_data_d;
  logic [31:0] pending_q, pending_d;
  logic        rf_wren_q, rf_wren_d;
  logic [4:0]  rf_addr_q, rf_addr_d;
  logic [31:0] rf_data_q, rf_data_d;

  logic wb_win;
  logic drain;
  logic accept;
  logic mdu_ready;

  assign mdu_ready = !buf_full_q && !aclr;

  always_comb begin
    wb_win = bus.wb_wren && (bus.wb_addr != '0);
    drain  = !wb_win && buf_full_q;
    accept = bus.mdu_valid && mdu_ready;

    rf_wren_d = 1'b0;
    rf_addr_d = '0;
    rf_data_d = '0;
    if (wb_win) begin
      rf_wren_d = 1'b1;
      rf_addr_d = bus.wb_addr;
      rf_data_d = bus.wb_data;
    end else if (drain && (buf_addr_q != '0)) begin
      // A buffered r0 result still drains, just without touching the port.
      rf_wren_d = 1'b1;
      rf_addr_d = buf_addr_q;
      rf_data_d = buf_data_q;
    end

    // Accept only happens while empty, so it never overlaps a drain.
    buf_full_d = buf_full_q;
    buf_addr_d = buf_addr_q;
    buf_data_d = buf_data_q;
    if (accept) begin
      buf_full_d = 1'b1;
      buf_addr_d = bus.mdu_addr;
      buf_data_d = bus.mdu_data;
    end else if (drain) begin
      buf_full_d = 1'b0;
    end

    // Clear first, then set, so a same-cycle reissue keeps the reservation.
    pending_d = pending_q;
    if (drain) begin
      pending_d[buf_addr_q] = 1'b0;
    end
    if (bus.mdu_issue && (bus.mdu_issue_addr != '0)) begin
      pending_d[bus.mdu_issue_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (aclr) begin
      buf_full_q <= 1'b0;
      buf_addr_q <= '0;
      buf_data_q <= '0;
      pending_q  <= '0;
      rf_wren_q  <= 1'b0;
      rf_addr_q  <= '0;
      rf_data_q  <= '0;
    end else begin
      buf_full_q <= buf_full_d;
      buf_addr_q <= buf_addr_d;
      buf_data_q <= buf_data_d;
      pending_q  <= pending_d;
      rf_wren_q  <= rf_wren_d;
      rf_addr_q  <= rf_addr_d;
      rf_data_q  <= rf_data_d;
    end
  end

`ifdef REGWR_ARB_STARVE_EN
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic [3:0] cnt_q, cnt_d;

  // Counts cycles the buffered result loses to WB; saturates so that a WB
  // write issued despite wb_stall leaves the count (and the stall) in place.
  always_comb begin
    cnt_d = cnt_q;
    if (!buf_full_q || drain) begin
      cnt_d = '0;
    end else if (wb_win && (cnt_q != STARVE_LIM)) begin
      cnt_d = cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (aclr) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bus.wb_stall = buf_full_q && (cnt_q == STARVE_LIM);
`else
  assign bus.wb_stall = 1'b0;
`endif

  assign bus.mdu_ready = mdu_ready;
  assign bus.busy_a    = pending_q[bus.busy_addr_a];
  assign bus.busy_b    = pending_q[bus.busy_addr_b];
  assign bus.rf_wren   = rf_wren_q;
  assign bus.rf_addr_w = rf_addr_q;
  assign bus.rf_data_w = rf_data_q;

endmodule

// File: tb/tb_regwr_arbiter.sv
// tb_regwr_arbiter
// Directed stimulus for regwr_arbiter. Every expected register-file write is
// queued when its stimulus is applied; a monitor on the falling edge pops and
// compares each write the DUT presents. Stall/ready/busy levels are checked
// inline by the driver one time unit after each rising edge.
module tb_regwr_arbiter;

`ifdef REGWR_ARB_STARVE_EN
  localparam bit STARVE_ON = 1'b1;
`else
  localparam bit STARVE_ON = 1'b0;
`endif

  logic clk;
  logic aclr;

  regwr_arbiter_if bus_if ();

  regwr_arbiter #(.STARVE_MAX(4)) dut (
    .clk  (clk),
    .aclr (aclr),
    .bus  (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  pass_cnt  = 0;
  int  total_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [4:0] a, input logic [31:0] d);
    wr_t w;
    w.addr = a;
    w.data = d;
    exp_q.push_back(w);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Write monitor: every asserted rf_wren must match the next queued write.
  always @(negedge clk) begin
    if (bus_if.rf_wren === 1'b1) begin
      if (exp_q.size() == 0) begin
        total_cnt++;
        $display("FAIL unexpected_write: got addr %0d data 0x%0h, expected no write at %0t",
                 bus_if.rf_addr_w, bus_if.rf_data_w, $time);
      end else begin
        wr_t w;
        w = exp_q.pop_front();
        chk("wr_addr", {27'd0, bus_if.rf_addr_w}, {27'd0, w.addr});
        chk("wr_data", bus_if.rf_data_w, w.data);
      end
    end
  end

  initial begin
    aclr                  = 1'b1;
    bus_if.wb_wren        = 1'b0;
    bus_if.wb_addr        = '0;
    bus_if.wb_data        = '0;
    bus_if.mdu_issue      = 1'b1;
    bus_if.mdu_issue_addr = 5'd5;
    bus_if.mdu_valid      = 1'b0;
    bus_if.mdu_addr       = '0;
    bus_if.mdu_data       = '0;
    bus_if.busy_addr_a    = 5'd5;
    bus_if.busy_addr_b    = 5'd0;

    // Reset held for two edges with an issue to r5 driven.
    for (int unsigned i = 0; i < 2; i++) begin
      step();
      chk("rst_rf_wren", {31'd0, bus_if.rf_wren}, 32'd0);
      chk("rst_mdu_ready", {31'd0, bus_if.mdu_ready}, 32'd0);
      chk("rst_busy_a", {31'd0, bus_if.busy_a}, 32'd0);
      chk("rst_wb_stall", {31'd0, bus_if.wb_stall}, 32'd0);
    end
    chk("rst_rf_addr", {27'd0, bus_if.rf_addr_w}, 32'd0);
    chk("rst_rf_data", bus_if.rf_data_w, 32'd0);
    aclr = 1'b0;
    bus_if.mdu_issue = 1'b0;
    #1;
    chk("post_rst_mdu_ready", {31'd0, bus_if.mdu_ready}, 32'd1);
    chk("post_rst_busy_a", {31'd0, bus_if.busy_a}, 32'd0);

    // WB write to r1, then a WB write to r0 that must be dropped.
    bus_if.wb_wren = 1'b1;
    bus_if.wb_addr = 5'd1;
    bus_if.wb_data = 32'hf0f0_f0f0;
    push(5'd1, 32'hf0f0_f0f0);
    step();
    chk("wb_r1_wren", {31'd0, bus_if.rf_wren}, 32'd1);
    bus_if.wb_addr = 5'd0;
    bus_if.wb_data = 32'hdead_beef;
    step();
    chk("wb_r0_wren", {31'd0, bus_if.rf_wren}, 32'd0);
    bus_if.wb_wren = 1'b0;

    // MDU flow to r5.
    bus_if.mdu_issue      = 1'b1;
    bus_if.mdu_issue_addr = 5'd5;
    step();
    bus_if.mdu_issue = 1'b0;
    chk("issue5_busy_a", {31'd0, bus_if.busy_a}, 32'd1);
    bus_if.mdu_valid = 1'b1;
    bus_if.mdu_addr  = 5'd5;
    bus_if.mdu_data  = 32'h1234_5678;
    push(5'd5, 32'h1234_5678);
    step();
    bus_if.mdu_valid = 1'b0;
    chk("mdu_full_ready", {31'd0, bus_if.mdu_ready}, 32'd0);
    chk("mdu_full_busy_a", {31'd0, bus_if.busy_a}, 32'd1);
    chk("mdu_full_wren", {31'd0, bus_if.rf_wren}, 32'd0);
    step();
    chk("mdu_drain_wren", {31'd0, bus_if.rf_wren}, 32'd1);
    chk("mdu_drain_busy_a", {31'd0, bus_if.busy_a}, 32'd0);
    chk("mdu_drain_ready", {31'd0, bus_if.mdu_ready}, 32'd1);

    // Contention: buffer holds r6 while WB writes r2 every cycle.
    bus_if.mdu_issue      = 1'b1;
    bus_if.mdu_issue_addr = 5'd6;
    step();
    bus_if.mdu_issue   = 1'b0;
    bus_if.busy_addr_b = 5'd6;
    bus_if.mdu_valid   = 1'b1;
    bus_if.mdu_addr    = 5'd6;
    bus_if.mdu_data    = 32'hcafe_babe;
    bus_if.wb_wren     = 1'b1;
    bus_if.wb_addr     = 5'd2;
    bus_if.wb_data     = 32'h0000_1000;
    push(5'd2, 32'h0000_1000);
    step();
    bus_if.mdu_valid = 1'b0;
    chk("cont_start_stall", {31'd0, bus_if.wb_stall}, 32'd0);
    chk("cont_start_ready", {31'd0, bus_if.mdu_ready}, 32'd0);
    for (int unsigned k = 1; k <= 5; k++) begin
      bus_if.wb_data = 32'h0000_1000 + k;
      push(5'd2, 32'h0000_1000 + k);
      step();
      chk($sformatf("cont_stall_%0d", k), {31'd0, bus_if.wb_stall},
          {31'd0, STARVE_ON && (k >= 4)});
      chk($sformatf("cont_busy_b_%0d", k), {31'd0, bus_if.busy_b}, 32'd1);
    end
    bus_if.wb_wren = 1'b0;
    push(5'd6, 32'hcafe_babe);
    step();
    chk("cont_drain_wren", {31'd0, bus_if.rf_wren}, 32'd1);
    chk("cont_drain_stall", {31'd0, bus_if.wb_stall}, 32'd0);
    chk("cont_drain_ready", {31'd0, bus_if.mdu_ready}, 32'd1);
    chk("cont_drain_busy_b", {31'd0, bus_if.busy_b}, 32'd0);

    // Buffered result for r0 drains silently.
    bus_if.mdu_valid = 1'b1;
    bus_if.mdu_addr  = 5'd0;
    bus_if.mdu_data  = 32'h0000_0005;
    step();
    bus_if.mdu_valid = 1'b0;
    chk("r0_full_ready", {31'd0, bus_if.mdu_ready}, 32'd0);
    step();
    chk("r0_drain_wren", {31'd0, bus_if.rf_wren}, 32'd0);
    chk("r0_drain_ready", {31'd0, bus_if.mdu_ready}, 32'd1);

    // Reissue to r7 in the same cycle as r7 drains: reservation survives.
    bus_if.mdu_issue      = 1'b1;
    bus_if.mdu_issue_addr = 5'd7;
    step();
    bus_if.mdu_issue = 1'b0;
    bus_if.mdu_valid = 1'b1;
    bus_if.mdu_addr  = 5'd7;
    bus_if.mdu_data  = 32'h0000_0077;
    step();
    bus_if.mdu_valid      = 1'b0;
    bus_if.mdu_issue      = 1'b1;
    bus_if.mdu_issue_addr = 5'd7;
    push(5'd7, 32'h0000_0077);
    step();
    bus_if.mdu_issue   = 1'b0;
    bus_if.busy_addr_a = 5'd7;
    #1;
    chk("same_cycle_busy7", {31'd0, bus_if.busy_a}, 32'd1);
    bus_if.mdu_valid = 1'b1;
    bus_if.mdu_data  = 32'h0000_0078;
    push(5'd7, 32'h0000_0078);
    step();
    bus_if.mdu_valid = 1'b0;
    step();
    chk("second_r7_busy", {31'd0, bus_if.busy_a}, 32'd0);

    // Reset while the buffer holds r9: r9 must never be written.
    bus_if.mdu_issue      = 1'b1;
    bus_if.mdu_issue_addr = 5'd9;
    step();
    bus_if.mdu_issue = 1'b0;
    bus_if.mdu_valid = 1'b1;
    bus_if.mdu_addr  = 5'd9;
    bus_if.mdu_data  = 32'h0000_0099;
    step();
    bus_if.mdu_valid = 1'b0;
    aclr = 1'b1;
    step();
    chk("mid_rst_wren", {31'd0, bus_if.rf_wren}, 32'd0);
    chk("mid_rst_ready", {31'd0, bus_if.mdu_ready}, 32'd0);
    aclr = 1'b0;
    bus_if.busy_addr_a = 5'd9;
    #1;
    chk("mid_rst_busy9", {31'd0, bus_if.busy_a}, 32'd0);
    chk("mid_rst_ready_after", {31'd0, bus_if.mdu_ready}, 32'd1);
    for (int unsigned i = 0; i < 3; i++) begin
      step();
    end

    @(negedge clk);
    #1;
    chk("queue_empty", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/regwr_arbiter.md
# regwr_arbiter

Write-port arbiter and scoreboard for the 32x32 general-purpose register file. Shares the register file's single write port between the in-order pipeline writeback stage and the multi-cycle multiply/divide unit (MDU), and tracks destinations reserved by in-flight MDU operations so the decode stage can stall on RAW hazards. It sits between WB/MDU and the regfiles `addr_w`/`data_w`/`wren` inputs; the register file's read ports are untouched.

## Interface
- `STARVE_MAX`, 4: consecutive cycles a buffered MDU result may lose to WB before `wb_stall` is raised (1..15).

- `clk`  in  1  clock, all state updates on rising edge
- `aclr`  in  1  reset; synchronous, active-high
- `wb_wren`  in  1  pipeline writeback request
- `wb_addr`  in  5  writeback destination
- `wb_data`  in  32  writeback data
- `wb_stall`  out  1  pipeline must hold `wb_wren`=0 this cycle
- `mdu_issue`  in  1  MDU op issued; reserve `mdu_issue_addr`
- `mdu_issue_addr`  in  5  destination of issued MDU op
- `mdu_valid`  in  1  MDU result available
- `mdu_ready`  out  1  result buffer can accept
- `mdu_addr`  in  5  MDU result destination
- `mdu_data`  in  32  MDU result data
- `busy_addr_a`, `busy_addr_b`  in  5 each  decode source registers
- `busy_a`, `busy_b`  out  1 each  source register has a pending MDU write
- `rf_wren`  out  1  to regfiles `wren`
- `rf_addr_w`  out  5  to regfiles `addr_w`
- `rf_data_w`  out  32  to regfiles `data_w`

## Operation
- State: one-entry MDU result buffer (`buf_full`, addr, data), 32-bit `pending` vector, starvation counter `cnt` (4 bits, saturating at `STARVE_MAX`), registered write-port outputs.
- MDU handshake: `mdu_ready` = !`buf_full` && !`aclr`. Transfer when `mdu_valid` && `mdu_ready`; the buffer captures addr/data. No accept while full; no accept-and-drain in the same cycle.
- Arbitration each cycle, fixed priority:
  - WB wins if `wb_wren` && `wb_addr`!=0.
  - Otherwise, if `buf_full`, drain the buffer.
  - Otherwise, no write.
- Writes to register 0 from either source are never sent to the port. A buffered MDU result to r0 is drained without asserting `rf_wren`.
- Scoreboard:
  - `mdu_issue` with addr!=0 sets `pending[addr]`.
  - Draining the buffer clears `pending[buf_addr]`.
  - Set and clear of the same addr in the same cycle: set wins.
  - `busy_a` = `pending[busy_addr_a]`, combinational from the register; same for `busy_b`.
- Starvation:
  - `cnt` increments each cycle the buffer is full and WB wins.
  - `cnt` clears when the buffer drains or is empty.
  - `wb_stall` = `buf_full` && `cnt`==`STARVE_MAX`, derived from flops only, with no input-to-output path.
  - If WB writes anyway during `wb_stall`, WB still wins and `cnt` holds.
- WAW ordering between WB and a pending MDU destination is the pipeline's responsibility, enforced through `busy_*`.

## Timing
- Write latency: request in cycle t produces `rf_wren`/`rf_addr_w`/`rf_data_w` in cycle t+1 and the register file updates at the end of t+1.
- MDU path: handshake at t sets `buf_full` at t+1. If WB is idle at t+1, `rf_wren` is asserted at t+2, `pending` clears at t+2, and `mdu_ready` returns to 1 at t+2.
- `busy_*` rises the cycle after `mdu_issue`.
- Reset values:
  - `rf_wren`=0, `rf_addr_w`=0, `rf_data_w`=0.
  - `buf_full`=0, `pending`=0, `cnt`=0.
  - `wb_stall`=0, `busy_*`=0, `mdu_ready`=0 while `aclr`=1.
- Reset mid-operation: buffered MDU data is discarded and never written, all pending bits clear, and `rf_wren`=0 the cycle after the reset edge.

## Configuration
- `REGWR_ARB_STARVE_EN`:
  - Defined: the starvation counter and `wb_stall` are implemented as above.
  - Undefined: `cnt` is not built and `wb_stall` is tied to 0. A buffered MDU result waits indefinitely until a cycle with no WB write, and `STARVE_MAX` is ignored.

## Test plan
- Reset: `aclr`=1 for 2 cycles with `mdu_issue` addr 5 driven -> `rf_wren`=0, `mdu_ready`=0, `busy_a`(addr 5)=0 throughout. After release, `mdu_ready`=1.
- WB write: `wb_wren`=1, addr 1, data 0xf0f0f0f0 at t -> at t+1 `rf_wren`=1, `rf_addr_w`=1, `rf_data_w`=0xf0f0f0f0. A WB write to addr 0 -> `rf_wren` stays 0.
- MDU flow:
  - Stimulus: issue addr 5; `busy_addr_a`=5 shows `busy_a`=1. Send `mdu_valid` data 0x12345678 with WB idle.
  - Response: `rf_wren`=1, addr 5 two cycles later; `busy_a`=0 and `mdu_ready`=1 the same cycle.
- Contention (macro defined, `STARVE_MAX`=4):
  - Stimulus: buffer full, `wb_wren`=1 addr 2 every cycle.
  - Response: WB is written each cycle and `wb_stall`=1 after 4 lost cycles. Once WB drops `wb_wren`, the MDU result commits the next cycle and `wb_stall` falls.
- Same-cycle issue to addr 7 while the buffered result for addr 7 drains -> `pending[7]` remains 1.
- `aclr` pulsed while the buffer holds addr 9 -> addr 9 is never written and `busy`(9)=0 after reset.
